ct_l2c_spsram_acc_ctrl: RTL and testbench
=========================================

Name: ct_l2c_spsram_acc_ctrl

Overview:
- Access controller directly upstream of the L2C 4096x84 single-port SRAM wrapper; sole driver of its A/CEN/GWEN/WEN/D pins and sole consumer of Q.
- Runs an init sweep after reset and on request, writing INIT_VAL to every entry.
- Then accepts pipelined read/write requests through a valid/ready handshake and returns read data with fixed latency.

Parameters:
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 84, SRAM data/bit-enable width.
- DEPTH, 4096, number of entries; sweep runs 0..DEPTH-1.
- INIT_VAL, 84'b0, value written by the init sweep.

Ports:
- forever_cpuclk  in  1  sole clock.
- cpurst  in  1  asynchronous, active-high reset.
- init_req  in  1  pulse: start a re-init sweep.
- init_busy  out  1  high while in DRAIN or INIT.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  entry index.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  active-high per-bit write enable.
- rsp_vld  out  1  read data valid, single-cycle pulse, no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data.
- ram_a  out  ADDR_WIDTH  to SRAM A.
- ram_cen  out  1  to SRAM CEN, active-low.
- ram_gwen  out  1  to SRAM GWEN, active-low global write enable.
- ram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit.
- ram_d  out  DATA_WIDTH  to SRAM D.
- ram_q  in  DATA_WIDTH  from SRAM Q, valid the cycle after a read access.

Behaviour:
- Reset values:
  - state = INIT, sweep counter = 0.
  - ram_cen = 1, ram_gwen = 1, ram_wen = all 1s, ram_a = 0, ram_d = 0.
  - rsp_vld = 0, rsp_rdata = 0, req_rdy = 0, init_busy = 1.
- All ram_* outputs are flops; there is no combinational path from req_* to ram_*.
- FSM has three states.
  - INIT:
    - Each cycle drives ram_cen = 0, ram_gwen = 0, ram_wen = all 0s, ram_a = counter, ram_d = INIT_VAL; counter then increments.
    - Write to address DEPTH-1 -> RUN, counter cleared.
    - The sweep takes exactly DEPTH cycles; req_rdy = 0 and init_req is ignored throughout.
  - RUN:
    - req_rdy = ~init_req, so init_req wins over a simultaneous req_vld.
    - init_req -> DRAIN.
  - DRAIN:
    - req_rdy = 0; waits until no read is in flight in stages S1/S2 -> INIT, counter = 0.
    - Takes 0-2 cycles.
- Pipeline for a request accepted in cycle T:
  - S1 (T+1): ram pins driven.
    - Read: cen = 0, gwen = 1, wen = all 1s, a = req_addr.
    - Write: cen = 0, gwen = 0, wen = ~req_wmask, d = req_wdata.
  - S2 (T+2): ram_q sampled into rsp_rdata.
  - rsp_vld = 1 during T+3 for reads only; read latency from accept to response is 3 cycles.
- Idle cycles (no accept) drive ram_cen = 1, gwen = 1, wen = all 1s; ram_a and ram_d hold their previous values.
- Throughput is one request per cycle; reads and writes mix freely.
  - A read accepted the cycle after a write to the same address returns the new data, since SRAM order is preserved.
- A write with req_wmask = 0 still issues cen = 0 with wen = all 1s, leaving contents unchanged.
- cpurst asserted mid-sweep or mid-pipeline:
  - Immediately returns to reset values and drops in-flight responses.
  - After release, restarts INIT from address 0.

Decomposition:
- Shared l2c package holds:
  - ADDR_WIDTH/DATA_WIDTH/DEPTH constants.
  - A 2-bit state encoding: INIT = 2'd0, RUN = 2'd1, DRAIN = 2'd2.
  - INIT_VAL.
- One natural sub-module: ct_l2c_spsram_init_cnt, holding the sweep counter with clear/increment and a last-address flag.
- The pipeline and FSM stay in the top module.

Test Plan:
- Reset release -> ram_cen low with gwen = 0 for exactly 4096 consecutive cycles, ram_a stepping 0..4095 with ram_d = 0; init_busy falls and req_rdy rises the following cycle.
- Write addr 0x123 data 84'hA5 mask all 1s, then read 0x123 next cycle -> rsp_vld 3 cycles after read accept with rsp_rdata = 84'hA5.
- Masked write to addr 5: data all 1s, mask 84'hF0 -> read 5 returns 84'hF0; ram_wen showed ~84'hF0 during S1.
- Back-to-back reads of addrs 1,2,3,4 over 4 cycles -> four consecutive rsp_vld pulses, data in order, starting 3 cycles after the first accept.
- init_req and req_vld asserted together in RUN with one read in flight -> req_rdy = 0, the in-flight read still responds, then the 4096-cycle sweep runs and a later read of 0x123 returns 0.
- cpurst pulsed when the sweep counter = 100 -> all outputs at reset values during reset; after release, the sweep restarts at ram_a = 0 and lasts 4096 cycles.

Source files
------------

// File: rtl/ct_l2c_spsram_acc_ctrl_pkg.sv
// Shared L2C SRAM access constants: geometry, init fill value and controller state encoding.
package ct_l2c_spsram_acc_ctrl_pkg;
   localparam int L2C_ADDR_W = 12;
   localparam int L2C_DATA_W = 84;
   localparam int L2C_DEPTH  = 4096;
   localparam int L2C_STAGES = 3;

   localparam logic [L2C_DATA_W-1:0] L2C_INIT_VAL = '0;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } l2c_state_e;
endpackage

// File: rtl/ct_l2c_spsram_init_cnt.sv
// Init sweep address counter: clear has priority over increment; last flags entry DEPTH-1.
module ct_l2c_spsram_init_cnt
   import ct_l2c_spsram_acc_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = L2C_ADDR_W,
   parameter int DEPTH      = L2C_DEPTH
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  clr,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] cnt,
   output logic                  last
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + 1'b1;
   end

   assign last = (cnt == LAST_ADDR);
endmodule

// File: rtl/ct_l2c_spsram_acc_ctrl.sv
// L2C single-port SRAM access controller: post-reset/requested init sweep, then a
// 3-cycle read pipeline (pins flopped in S1, Q captured in S2, response in S3).
module ct_l2c_spsram_acc_ctrl
   import ct_l2c_spsram_acc_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH = L2C_ADDR_W,
   parameter int                    DATA_WIDTH = L2C_DATA_W,
   parameter int                    DEPTH      = L2C_DEPTH,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = L2C_INIT_VAL
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  init_req,
   output logic                  init_busy,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic                  ram_cen,
   output logic                  ram_gwen,
   output logic [DATA_WIDTH-1:0] ram_wen,
   output logic [DATA_WIDTH-1:0] ram_d,
   input  logic [DATA_WIDTH-1:0] ram_q
);
   localparam int STAGES = L2C_STAGES;

   l2c_state_e            state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  cnt_last;
   logic                  cnt_clr;
   logic                  cnt_inc;
   logic                  acc;
   logic                  rd_acc;
   logic                  drained;
   logic [STAGES:1]       vld_pipe;

   // init_req outranks a same-cycle request so DRAIN never sees a new read behind it
   assign req_rdy   = (state == ST_RUN) & ~init_req;
   assign init_busy = (state != ST_RUN);
   assign acc       = req_vld & req_rdy;
   assign rd_acc    = acc & ~req_wr;
   assign drained   = ~vld_pipe[1] & ~vld_pipe[2];

   assign cnt_inc = (state == ST_INIT);
   assign cnt_clr = ((state == ST_INIT) & cnt_last) | ((state == ST_DRAIN) & drained);

   ct_l2c_spsram_init_cnt #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_init_cnt (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .clr            (cnt_clr),
      .inc            (cnt_inc),
      .cnt            (cnt),
      .last           (cnt_last)
   );

   // FSM and SRAM pin flops; idle cycles deselect but keep A/D stable
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state    <= ST_INIT;
         ram_cen  <= 1'b1;
         ram_gwen <= 1'b1;
         ram_wen  <= '1;
         ram_a    <= '0;
         ram_d    <= '0;
      end else begin
         ram_cen  <= 1'b1;
         ram_gwen <= 1'b1;
         ram_wen  <= '1;
         case (state)
            ST_INIT: begin
               ram_cen  <= 1'b0;
               ram_gwen <= 1'b0;
               ram_wen  <= '0;
               ram_a    <= cnt;
               ram_d    <= INIT_VAL;
               if (cnt_last)
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (acc) begin
                  ram_cen <= 1'b0;
                  ram_a   <= req_addr;
                  if (req_wr) begin
                     ram_gwen <= 1'b0;
                     ram_wen  <= ~req_wmask;
                     ram_d    <= req_wdata;
                  end
               end
               if (init_req)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drained)
                  state <= ST_INIT;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // read valid tracks S1 -> S2 -> response; Q is captured while the read sits in S2
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         vld_pipe  <= '0;
         rsp_rdata <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], rd_acc};
         if (vld_pipe[2])
            rsp_rdata <= ram_q;
      end
   end

   assign rsp_vld = vld_pipe[STAGES];
endmodule

// File: tb/tb_ct_l2c_spsram_acc_ctrl.sv
// Directed bench for ct_l2c_spsram_acc_ctrl with a behavioural 4096x84 SRAM on the pins.
module tb_ct_l2c_spsram_acc_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        init_req;
   logic        init_busy;
   logic        req_vld;
   logic        req_rdy;
   logic        req_wr;
   logic [11:0] req_addr;
   logic [83:0] req_wdata;
   logic [83:0] req_wmask;
   logic        rsp_vld;
   logic [83:0] rsp_rdata;
   logic [11:0] ram_a;
   logic        ram_cen;
   logic        ram_gwen;
   logic [83:0] ram_wen;
   logic [83:0] ram_d;
   logic [83:0] ram_q;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [83:0] mem [0:4095];
   logic [83:0] b2b_d [4] = '{84'h111, 84'h2222_0000, 84'h3_3333_3333, 84'hF0000_0000_0000_0000_4444};

   always #5 clk = ~clk;

   ct_l2c_spsram_acc_ctrl dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .init_req       (init_req),
      .init_busy      (init_busy),
      .req_vld        (req_vld),
      .req_rdy        (req_rdy),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_wmask      (req_wmask),
      .rsp_vld        (rsp_vld),
      .rsp_rdata      (rsp_rdata),
      .ram_a          (ram_a),
      .ram_cen        (ram_cen),
      .ram_gwen       (ram_gwen),
      .ram_wen        (ram_wen),
      .ram_d          (ram_d),
      .ram_q          (ram_q)
   );

   // SRAM: write bits where WEN is low; read data appears the cycle after the access
   always @(posedge clk) begin
      if (!ram_cen) begin
         if (!ram_gwen)
            mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
         else
            ram_q <= mem[ram_a];
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic wr, input logic [11:0] a,
                      input logic [83:0] d, input logic [83:0] m);
      req_vld   = v;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
   endtask

   task automatic watch_sweep(input string nm);
      int n   = 0;
      int bad = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (!ram_cen) begin
            if (ram_a !== 12'(n) || ram_gwen !== 1'b0 || ram_wen !== '0 || ram_d !== '0 ||
                (n < 4095 && init_busy !== 1'b1))
               bad++;
            n++;
         end else if (n > 0) begin
            break;
         end
      end
      chk_cnt++; if (n != 4096) $display("FAIL %s sweep_len: got %0d exp 4096", nm, n); else pass_cnt++;
      chk_cnt++; if (bad != 0) $display("FAIL %s sweep_pins: got %0d bad cycles exp 0", nm, bad); else pass_cnt++;
      chk_cnt++; if (init_busy !== 1'b0) $display("FAIL %s busy_after: got %b exp 0", nm, init_busy); else pass_cnt++;
      chk_cnt++; if (req_rdy !== 1'b1) $display("FAIL %s rdy_after: got %b exp 1", nm, req_rdy); else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      init_req = 1'b0;
      drv(1'b0, 1'b0, 12'h0, '0, '0);
      repeat (3) @(negedge clk);
      chk_cnt++; if (ram_cen !== 1'b1) $display("FAIL rst ram_cen: got %b exp 1", ram_cen); else pass_cnt++;
      chk_cnt++; if (ram_gwen !== 1'b1) $display("FAIL rst ram_gwen: got %b exp 1", ram_gwen); else pass_cnt++;
      chk_cnt++; if (ram_wen !== '1) $display("FAIL rst ram_wen: got %h exp all 1", ram_wen); else pass_cnt++;
      chk_cnt++; if (ram_a !== 12'h0) $display("FAIL rst ram_a: got %h exp 0", ram_a); else pass_cnt++;
      chk_cnt++; if (ram_d !== '0) $display("FAIL rst ram_d: got %h exp 0", ram_d); else pass_cnt++;
      chk_cnt++; if (rsp_vld !== 1'b0) $display("FAIL rst rsp_vld: got %b exp 0", rsp_vld); else pass_cnt++;
      chk_cnt++; if (rsp_rdata !== '0) $display("FAIL rst rsp_rdata: got %h exp 0", rsp_rdata); else pass_cnt++;
      chk_cnt++; if (req_rdy !== 1'b0) $display("FAIL rst req_rdy: got %b exp 0", req_rdy); else pass_cnt++;
      chk_cnt++; if (init_busy !== 1'b1) $display("FAIL rst init_busy: got %b exp 1", init_busy); else pass_cnt++;
      rst = 1'b0;
      watch_sweep("boot");
   endtask

   task automatic test_write_read();
      nxt(); drv(1'b1, 1'b1, 12'h123, 84'hA5, '1);
      @(negedge clk);
      chk_cnt++; if (req_rdy !== 1'b1) $display("FAIL wr_rd wr_rdy: got %b exp 1", req_rdy); else pass_cnt++;
      nxt(); drv(1'b1, 1'b0, 12'h123, '0, '0);
      @(negedge clk);
      chk_cnt++; if (ram_cen !== 1'b0 || ram_gwen !== 1'b0) $display("FAIL wr_rd wr_s1_en: got cen %b gwen %b exp 0 0", ram_cen, ram_gwen); else pass_cnt++;
      chk_cnt++; if (ram_a !== 12'h123 || ram_d !== 84'hA5 || ram_wen !== '0) $display("FAIL wr_rd wr_s1_pins: got a %h d %h wen %h", ram_a, ram_d, ram_wen); else pass_cnt++;
      nxt(); drv(1'b0, 1'b0, 12'h0, '0, '0);
      @(negedge clk);
      chk_cnt++; if (ram_cen !== 1'b0 || ram_gwen !== 1'b1 || ram_wen !== '1 || ram_a !== 12'h123) $display("FAIL wr_rd rd_s1: got cen %b gwen %b a %h", ram_cen, ram_gwen, ram_a); else pass_cnt++;
      nxt(); @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b0) $display("FAIL wr_rd early_rsp: got %b exp 0", rsp_vld); else pass_cnt++;
      nxt(); @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b1) $display("FAIL wr_rd rsp_vld: got %b exp 1", rsp_vld); else pass_cnt++;
      chk_cnt++; if (rsp_rdata !== 84'hA5) $display("FAIL wr_rd rsp_rdata: got %h exp a5", rsp_rdata); else pass_cnt++;
      nxt(); @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b0) $display("FAIL wr_rd rsp_pulse: got %b exp 0", rsp_vld); else pass_cnt++;
      chk_cnt++; if (ram_cen !== 1'b1 || ram_a !== 12'h123) $display("FAIL wr_rd idle_hold: got cen %b a %h exp 1 123", ram_cen, ram_a); else pass_cnt++;
   endtask

   task automatic test_masked_write();
      nxt(); drv(1'b1, 1'b1, 12'h5, '1, 84'hF0);
      nxt(); drv(1'b1, 1'b0, 12'h5, '0, '0);
      @(negedge clk);
      chk_cnt++; if (ram_wen !== ~84'hF0 || ram_gwen !== 1'b0 || ram_a !== 12'h5) $display("FAIL mask wen_s1: got wen %h gwen %b a %h", ram_wen, ram_gwen, ram_a); else pass_cnt++;
      nxt(); drv(1'b1, 1'b1, 12'h5, '0, '0);
      nxt(); drv(1'b1, 1'b0, 12'h5, '0, '0);
      @(negedge clk);
      chk_cnt++; if (ram_cen !== 1'b0 || ram_wen !== '1) $display("FAIL mask zero_mask_s1: got cen %b wen %h exp 0 all 1", ram_cen, ram_wen); else pass_cnt++;
      nxt(); drv(1'b0, 1'b0, 12'h0, '0, '0);
      @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b1 || rsp_rdata !== 84'hF0) $display("FAIL mask rd1: got vld %b data %h exp 1 f0", rsp_vld, rsp_rdata); else pass_cnt++;
      nxt(); @(negedge clk);
      nxt(); @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b1 || rsp_rdata !== 84'hF0) $display("FAIL mask rd_after_zero: got vld %b data %h exp 1 f0", rsp_vld, rsp_rdata); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         nxt(); drv(1'b1, 1'b1, 12'(i + 1), b2b_d[i], '1);
      end
      for (int k = 0; k < 8; k++) begin
         nxt();
         if (k < 4) drv(1'b1, 1'b0, 12'(k + 1), '0, '0);
         else drv(1'b0, 1'b0, 12'h0, '0, '0);
         @(negedge clk);
         if (k < 4) begin
            chk_cnt++; if (req_rdy !== 1'b1) $display("FAIL b2b rdy%0d: got %b exp 1", k, req_rdy); else pass_cnt++;
         end
         if (k >= 3 && k <= 6) begin
            chk_cnt++; if (rsp_vld !== 1'b1 || rsp_rdata !== b2b_d[k-3]) $display("FAIL b2b rsp%0d: got vld %b data %h exp 1 %h", k - 3, rsp_vld, rsp_rdata, b2b_d[k-3]); else pass_cnt++;
         end else if (k == 2 || k == 7) begin
            chk_cnt++; if (rsp_vld !== 1'b0) $display("FAIL b2b edge%0d: got %b exp 0", k, rsp_vld); else pass_cnt++;
         end
      end
   endtask

   task automatic test_init_req();
      nxt(); drv(1'b1, 1'b0, 12'h123, '0, '0);
      nxt(); drv(1'b1, 1'b0, 12'h10, '0, '0); init_req = 1'b1;
      @(negedge clk);
      chk_cnt++; if (req_rdy !== 1'b0) $display("FAIL ireq rdy_blocked: got %b exp 0", req_rdy); else pass_cnt++;
      nxt(); drv(1'b0, 1'b0, 12'h0, '0, '0); init_req = 1'b0;
      @(negedge clk);
      chk_cnt++; if (init_busy !== 1'b1) $display("FAIL ireq busy_drain: got %b exp 1", init_busy); else pass_cnt++;
      nxt(); @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b1 || rsp_rdata !== 84'hA5) $display("FAIL ireq inflight_rsp: got vld %b data %h exp 1 a5", rsp_vld, rsp_rdata); else pass_cnt++;
      nxt(); @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b0) $display("FAIL ireq rejected_rsp: got %b exp 0", rsp_vld); else pass_cnt++;
      watch_sweep("reinit");
      nxt(); drv(1'b1, 1'b0, 12'h123, '0, '0);
      nxt(); drv(1'b0, 1'b0, 12'h0, '0, '0);
      nxt(); nxt(); @(negedge clk);
      chk_cnt++; if (rsp_vld !== 1'b1 || rsp_rdata !== '0) $display("FAIL ireq cleared: got vld %b data %h exp 1 0", rsp_vld, rsp_rdata); else pass_cnt++;
   endtask

   task automatic test_reset_mid_sweep();
      logic hit = 1'b0;
      nxt(); init_req = 1'b1;
      nxt(); init_req = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!ram_cen && ram_a == 12'd99) begin
            hit = 1'b1;
            break;
         end
      end
      chk_cnt++; if (hit !== 1'b1) $display("FAIL midrst reach_99: got %b exp 1", hit); else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++; if (ram_cen !== 1'b1 || ram_gwen !== 1'b1 || ram_wen !== '1) $display("FAIL midrst ctl: got cen %b gwen %b wen %h", ram_cen, ram_gwen, ram_wen); else pass_cnt++;
      chk_cnt++; if (ram_a !== 12'h0 || ram_d !== '0) $display("FAIL midrst addr_data: got a %h d %h exp 0 0", ram_a, ram_d); else pass_cnt++;
      chk_cnt++; if (init_busy !== 1'b1 || req_rdy !== 1'b0 || rsp_vld !== 1'b0) $display("FAIL midrst status: got busy %b rdy %b vld %b", init_busy, req_rdy, rsp_vld); else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      watch_sweep("midrst");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_masked_write();
      test_back_to_back();
      test_init_req();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
